// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer slice.
// Contents: register-file geometry (REG_ADDR_W, XLEN), default tag width,
// the 37-bit register-file word {tag, value}, and TAG_NONE, the tag value
// meaning "the architectural register already holds the value".
package reorder_buffer_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int TAG_W      = 5;
  localparam int RF_ENTRY_W = TAG_W + XLEN;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  // Word written into either register-file write port.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } rf_word_t;

endpackage

// File: rtl/rob_youngest_match.sv
// Residual-tag search for the commit port.
// Finds the youngest busy entry strictly after head (up to tail-1, i.e. the
// first count-1 entries after head) whose destination equals match_rd, and
// returns its tag (index + 1), or TAG_NONE when no newer rename exists.
// Ports:
//   head     - index of the committing (oldest) entry
//   count    - current occupancy
//   busy     - per-entry busy flags
//   rd       - per-entry destination registers
//   match_rd - destination of the committing entry
//   tag      - residual tag for the committed register-file word
module rob_youngest_match
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 5,
  parameter int TAG_W = 5
) (
  input  logic [IDX_W-1:0]      head,
  input  logic [CNT_W-1:0]      count,
  input  logic [DEPTH-1:0]      busy,
  input  logic [REG_ADDR_W-1:0] rd [DEPTH],
  input  logic [REG_ADDR_W-1:0] match_rd,
  output logic [TAG_W-1:0]      tag
);

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the youngest matching rename wins.
  always_comb begin
    int pos;
    logic [IDX_W-1:0] idx;
    tag = TAG_NONE;
    pos = 0;
    idx = '0;
    for (int k = 1; k < DEPTH; k++) begin
      if (k < int'(count)) begin
        pos = int'(head) + k;
        if (pos >= DEPTH) pos = pos - DEPTH;
        idx = IDX_W'(pos);
        if (busy[idx] && (rd[idx] == match_rd)) tag = TAG_W'(pos + 1);
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer.
// Allocates a rename tag (entry index + 1) per dispatch and drives the
// register file rename port; captures CDB results; retires the head entry
// through the commit port, and on a mispredicted head drives flush and the
// redirect PC while discarding every entry.
// Optional: define ROB_WB_BYPASS_EN to let operand queries see a CDB result
// in the same cycle it is broadcast (commit is unaffected).
// Ports:
//   clk, rst (sync, active high), rdy (global enable)
//   disp_valid/disp_rd -> disp_ready/disp_tag        : dispatch handshake
//   wb_valid/wb_tag/wb_value/wb_mispredict/wb_target  : CDB result
//   query_tag1/2 -> query_ready1/2, query_value1/2    : operand lookup
//   rf_rename_en/addr/data                            : register file port 1
//   rf_commit_en/addr/data                            : register file port 2
//   flush, redirect_pc                                : mispredict recovery
// Handshake: a dispatch is taken on a cycle where disp_valid, disp_ready and
// rdy are all high; disp_ready never depends on disp_valid.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  disp_valid,
  input  logic [REG_ADDR_W-1:0] disp_rd,
  output logic                  disp_ready,
  output logic [TAG_W-1:0]      disp_tag,
  input  logic                  wb_valid,
  input  logic [TAG_W-1:0]      wb_tag,
  input  logic [XLEN-1:0]       wb_value,
  input  logic                  wb_mispredict,
  input  logic [XLEN-1:0]       wb_target,
  input  logic [TAG_W-1:0]      query_tag1,
  input  logic [TAG_W-1:0]      query_tag2,
  output logic                  query_ready1,
  output logic                  query_ready2,
  output logic [XLEN-1:0]       query_value1,
  output logic [XLEN-1:0]       query_value2,
  output logic                  rf_rename_en,
  output logic [REG_ADDR_W-1:0] rf_rename_addr,
  output logic [RF_ENTRY_W-1:0] rf_rename_data,
  output logic                  rf_commit_en,
  output logic [REG_ADDR_W-1:0] rf_commit_addr,
  output logic [RF_ENTRY_W-1:0] rf_commit_data,
  output logic                  flush,
  output logic [XLEN-1:0]       redirect_pc
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TAG_W-1:0] MAX_TAG  = TAG_W'(DEPTH);

  logic [DEPTH-1:0]      busy_q, ready_q, mis_q;
  logic [REG_ADDR_W-1:0] rd_q     [DEPTH];
  logic [XLEN-1:0]       value_q  [DEPTH];
  logic [XLEN-1:0]       target_q [DEPTH];
  logic [IDX_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;

  logic             accept, commit, wb_hit;
  logic [IDX_W-1:0] wb_idx, head_next, tail_next;
  logic [TAG_W-1:0] residual_tag;
  rf_word_t         commit_word;

  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
    return IDX_W'(t - TAG_W'(1));
  endfunction

  function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
    return (t != TAG_NONE) && (t <= MAX_TAG);
  endfunction

  // Commit and its flush are suppressed in the reset cycle so stale state
  // can never reach the register file.
  assign commit      = !rst && rdy && busy_q[head_q] && ready_q[head_q];
  assign flush       = commit && mis_q[head_q];
  assign redirect_pc = flush ? target_q[head_q] : '0;

  // A commit in the same cycle does not free a slot for a full buffer.
  assign disp_ready = rst || ((count_q < FULL_CNT) && !flush);
  assign disp_tag   = rst ? TAG_W'(1) : TAG_W'(tail_q) + TAG_W'(1);
  assign accept     = !rst && rdy && disp_valid && disp_ready;

  assign rf_rename_en   = accept && (disp_rd != '0);
  assign rf_rename_addr = rf_rename_en ? disp_rd : '0;
  assign rf_rename_data = rf_rename_en ? {disp_tag, {XLEN{1'b0}}} : '0;

  rob_youngest_match #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W),
    .CNT_W(CNT_W),
    .TAG_W(TAG_W)
  ) u_match (
    .head     (head_q),
    .count    (count_q),
    .busy     (busy_q),
    .rd       (rd_q),
    .match_rd (rd_q[head_q]),
    .tag      (residual_tag)
  );

  assign commit_word.tag   = residual_tag;
  assign commit_word.value = value_q[head_q];
  assign rf_commit_en      = commit && (rd_q[head_q] != '0);
  assign rf_commit_addr    = commit ? rd_q[head_q] : '0;
  assign rf_commit_data    = commit ? commit_word : '0;

  assign wb_idx = tag_idx(wb_tag);
  assign wb_hit = !rst && rdy && wb_valid && tag_in_range(wb_tag) && busy_q[wb_idx];

  assign head_next = (head_q == LAST_IDX) ? '0 : head_q + IDX_W'(1);
  assign tail_next = (tail_q == LAST_IDX) ? '0 : tail_q + IDX_W'(1);

  // Operand queries; only busy entries answer.
  logic [TAG_W-1:0] q_tag   [2];
  logic             q_ready [2];
  logic [XLEN-1:0]  q_value [2];

  assign q_tag[0]     = query_tag1;
  assign q_tag[1]     = query_tag2;
  assign query_ready1 = q_ready[0];
  assign query_ready2 = q_ready[1];
  assign query_value1 = q_value[0];
  assign query_value2 = q_value[1];

  always_comb begin
    for (int q = 0; q < 2; q++) begin
      q_ready[q] = 1'b0;
      q_value[q] = '0;
      if (tag_in_range(q_tag[q]) && busy_q[tag_idx(q_tag[q])]) begin
        if (ready_q[tag_idx(q_tag[q])]) begin
          q_ready[q] = 1'b1;
          q_value[q] = value_q[tag_idx(q_tag[q])];
        end
`ifdef ROB_WB_BYPASS_EN
        if (wb_valid && (wb_tag == q_tag[q])) begin
          q_ready[q] = 1'b1;
          q_value[q] = wb_value;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
    end else if (rdy) begin
      if (wb_hit) begin
        ready_q[wb_idx]  <= 1'b1;
        value_q[wb_idx]  <= wb_value;
        mis_q[wb_idx]    <= wb_mispredict;
        target_q[wb_idx] <= wb_target;
      end
      if (commit) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_next;
      end
      if (accept) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        rd_q[tail_q]    <= disp_rd;
        tail_q          <= tail_next;
      end
      case ({accept, commit})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // Mispredict recovery overrides everything above.
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        busy_q  <= '0;
        ready_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then randomized traffic,
// checked against a queue-based in-order model of the buffer.
module tb_reorder_buffer;

  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        disp_valid = 1'b0;
  logic [4:0]  disp_rd = '0;
  logic        disp_ready;
  logic [4:0]  disp_tag;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_tag = '0;
  logic [31:0] wb_value = '0;
  logic        wb_mispredict = 1'b0;
  logic [31:0] wb_target = '0;
  logic [4:0]  query_tag1 = '0, query_tag2 = '0;
  logic        query_ready1, query_ready2;
  logic [31:0] query_value1, query_value2;
  logic        rf_rename_en, rf_commit_en, flush;
  logic [4:0]  rf_rename_addr, rf_commit_addr;
  logic [36:0] rf_rename_data, rf_commit_data;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .disp_valid(disp_valid), .disp_rd(disp_rd),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .rf_rename_en(rf_rename_en), .rf_rename_addr(rf_rename_addr),
    .rf_rename_data(rf_rename_data),
    .rf_commit_en(rf_commit_en), .rf_commit_addr(rf_commit_addr),
    .rf_commit_data(rf_commit_data),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // commit: {commit_en, addr, {tag, value}, flush, redirect_pc}
  logic [75:0] exp_q[$];
  // rename: {addr, {tag, 32'b0}}
  logic [41:0] ren_q[$];

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rf_commit_en || flush) begin
        if (exp_q.size() == 0)
          chk("commit_unexpected", {rf_commit_en, rf_commit_addr, rf_commit_data, flush, redirect_pc}, 76'd0);
        else
          chk("commit", {rf_commit_en, rf_commit_addr, rf_commit_data, flush, redirect_pc}, exp_q.pop_front());
      end
      if (rf_rename_en) begin
        if (ren_q.size() == 0)
          chk("rename_unexpected", {rf_rename_addr, rf_rename_data}, 76'd0);
        else
          chk("rename", {rf_rename_addr, rf_rename_data}, {34'd0, ren_q.pop_front()});
      end
    end
  end

  // ---------------- reference model ----------------
  // The buffer is an ordered list of in-flight instructions, oldest first.
  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  rd;
    bit          rdy;
    logic [31:0] val;
    bit          mis;
    logic [31:0] tgt;
  } ent_t;

  ent_t       rob[$];
  logic [4:0] next_tag = 5'd1;
  logic [4:0] q1_sel = '0, q2_sel = '0;

  function automatic logic [32:0] q_model(input logic [4:0] t, input logic wv,
                                          input logic [4:0] wt, input logic [31:0] wval);
    logic [32:0] r;
    r = '0;
    foreach (rob[i]) begin
      if (t != 0 && rob[i].tag == t) begin
        if (rob[i].rdy) r = {1'b1, rob[i].val};
`ifdef ROB_WB_BYPASS_EN
        if (wv && wt == t) r = {1'b1, wval};
`endif
      end
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic dv, input logic [4:0] drd, input logic wv,
                      input logic [4:0] wt, input logic [31:0] wval, input logic wmis,
                      input logic [31:0] wtgt, input logic r);
    bit c, fl, dr, acc;
    logic [4:0] res;
    ent_t e;
    @(posedge clk); #1;
    rst = 1'b0; rdy = r;
    disp_valid = dv; disp_rd = drd;
    wb_valid = wv; wb_tag = wt; wb_value = wval; wb_mispredict = wmis; wb_target = wtgt;
    query_tag1 = q1_sel; query_tag2 = q2_sel;

    c   = r && rob.size() > 0 && rob[0].rdy;
    fl  = c && rob[0].mis;
    dr  = (rob.size() < DEPTH) && !fl;
    acc = r && dv && dr;
    if (c) begin
      res = '0;
      for (int i = 1; i < rob.size(); i++)
        if (rob[i].rd == rob[0].rd) res = rob[i].tag;
      if (rob[0].rd != 0 || fl)
        exp_q.push_back({rob[0].rd != 0, rob[0].rd, res, rob[0].val, fl, fl ? rob[0].tgt : 32'h0});
    end
    if (acc && drd != 0) ren_q.push_back({drd, next_tag, 32'h0});

    @(negedge clk);
    chk("disp_ready", disp_ready, dr);
    chk("disp_tag", disp_tag, next_tag);
    chk("query1", {query_ready1, query_value1}, q_model(q1_sel, wv, wt, wval));
    chk("query2", {query_ready2, query_value2}, q_model(q2_sel, wv, wt, wval));

    if (c) begin
      if (fl) begin
        rob.delete();
        next_tag = 5'd1;
      end else begin
        void'(rob.pop_front());
      end
    end
    if (r && wv && !fl) begin
      foreach (rob[i]) begin
        if (rob[i].tag == wt) begin
          rob[i].rdy = 1'b1; rob[i].val = wval; rob[i].mis = wmis; rob[i].tgt = wtgt;
        end
      end
    end
    if (acc) begin
      e.tag = next_tag; e.rd = drd; e.rdy = 1'b0; e.val = '0; e.mis = 1'b0; e.tgt = '0;
      rob.push_back(e);
      next_tag = (next_tag == 5'(DEPTH)) ? 5'd1 : next_tag + 5'd1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rdy = 1'b1; disp_valid = 1'b1; disp_rd = 5'd3; wb_valid = 1'b0;
    @(negedge clk);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_disp_tag", disp_tag, 1);
    chk("rst_rename_en", rf_rename_en, 0);
    chk("rst_commit_en", rf_commit_en, 0);
    chk("rst_flush", flush, 0);
    rob.delete();
    next_tag = 5'd1;
  endtask

  task automatic disp(input logic [4:0] rd);
    step(1'b1, rd, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic wb(input logic [4:0] t, input logic [31:0] v, input logic m, input logic [31:0] tg);
    step(1'b0, 5'd0, 1'b1, t, v, m, tg, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pend[$];
    logic        dv, wv, wmis, r;
    logic [4:0]  drd, wt;
    logic [31:0] wval, wtgt;

    // single instruction round trip
    do_reset();
    disp(5'd5);
    chk("t1_rename_en", rf_rename_en, 1);
    chk("t1_rename_data", rf_rename_data, {5'd1, 32'h0});
    wb(5'd1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    idle();
    chk("t1_commit_en", rf_commit_en, 1);
    chk("t1_commit_addr", rf_commit_addr, 5);
    chk("t1_commit_data", rf_commit_data, {5'd0, 32'hDEAD_BEEF});

    // residual tag keeps the newer rename of the same register
    do_reset();
    disp(5'd7);
    disp(5'd7);
    wb(5'd1, 32'd10, 1'b0, 32'h0);
    idle();
    chk("t2_commit_data1", rf_commit_data, {5'd2, 32'd10});
    wb(5'd2, 32'd20, 1'b0, 32'h0);
    idle();
    chk("t2_commit_data2", rf_commit_data, {5'd0, 32'd20});

    // full boundary and tail wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) disp(5'(i % 7 + 1));
    step(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("t3_full_ready", disp_ready, 0);
    chk("t3_full_rename", rf_rename_en, 0);
    wb(5'd1, 32'h1234, 1'b0, 32'h0);
    step(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("t3_commit_full_en", rf_commit_en, 1);
    chk("t3_commit_full_ready", disp_ready, 0);
    idle();
    chk("t3_wrap_ready", disp_ready, 1);
    chk("t3_wrap_tag", disp_tag, 1);

    // mispredict at commit
    do_reset();
    disp(5'd1);
    disp(5'd2);
    disp(5'd3);
    wb(5'd1, 32'h77, 1'b1, 32'h0000_1000);
    idle();
    chk("t4_flush", flush, 1);
    chk("t4_redirect", redirect_pc, 32'h1000);
    chk("t4_link_commit", rf_commit_en, 1);
    q1_sel = 5'd2;
    idle();
    chk("t4_tag_after", disp_tag, 1);
    chk("t4_query_after", query_ready1, 0);
    q1_sel = 5'd0;

    // rd = 0 neither renames nor writes, but still retires
    do_reset();
    disp(5'd0);
    chk("t5_rename_rd0", rf_rename_en, 0);
    wb(5'd1, 32'h5, 1'b0, 32'h0);
    idle();
    chk("t5_commit_rd0", rf_commit_en, 0);
    disp(5'd4);
    chk("t5_next_tag", disp_tag, 2);
    wb(5'd2, 32'h6, 1'b0, 32'h0);
    idle();
    chk("t5_commit_next", {rf_commit_en, rf_commit_addr}, {1'b1, 5'd4});

    // writeback visibility to operand queries
    do_reset();
    disp(5'd4);
    disp(5'd5);
    disp(5'd6);
    q1_sel = 5'd3;
    wb(5'd3, 32'h55, 1'b0, 32'h0);
`ifdef ROB_WB_BYPASS_EN
    chk("t6_bypass", {query_ready1, query_value1}, {1'b1, 32'h55});
`else
    chk("t6_no_bypass", query_ready1, 0);
`endif
    idle();
    chk("t6_next_cycle", {query_ready1, query_value1}, {1'b1, 32'h55});
    q1_sel = 5'd0;

    // reset while the head is ready: nothing may commit in the reset cycle
    wb(5'd1, 32'h9, 1'b0, 32'h0);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        do_reset();
      end else begin
        q1_sel = 5'($urandom_range(0, DEPTH));
        q2_sel = 5'($urandom_range(0, DEPTH));
        dv   = ($urandom_range(0, 3) != 0);
        drd  = 5'($urandom_range(0, 7));
        r    = ($urandom_range(0, 9) != 0);
        wmis = ($urandom_range(0, 15) == 0);
        wval = $urandom;
        wtgt = $urandom;
        wv   = 1'b0;
        wt   = '0;
        pend.delete();
        foreach (rob[i]) if (!rob[i].rdy) pend.push_back(i);
        if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
          wv = 1'b1;
          wt = rob[pend[$urandom_range(0, pend.size() - 1)]].tag;
        end else if ($urandom_range(0, 7) == 0) begin
          wv = 1'b1;
          wt = 5'($urandom_range(0, 31));
        end
        if (wv && $urandom_range(0, 2) == 0) q1_sel = wt;
        step(dv, drd, wv, wt, wval, wmis, wtgt, r);
      end
    end

    idle();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("ren_q_drained", ren_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
